// File: rtl/run_light_ctrl_if.sv
// Button inputs and step outputs shared by the run-light controller and its consumer.
// master = controller side, slave = shifter/stimulus side.
interface run_light_ctrl_if #(
   parameter int NUM_SPEEDS = 4
);
   localparam int SPW = $clog2(NUM_SPEEDS);

   logic           btn_mode;
   logic           btn_dir;
   logic           pulse;
   logic           dir;
   logic           running;
   logic [SPW-1:0] speed;

   modport master (
      input  btn_mode, btn_dir,
      output pulse, dir, running, speed
   );

   modport slave (
      output btn_mode, btn_dir,
      input  pulse, dir, running, speed
   );
endinterface

// File: rtl/run_light_ctrl.sv
// Run-light sequencer: debounced mode/dir buttons, STOP/RUN FSM, step prescaler and dir control.
// A raw button rise takes effect DEBOUNCE_CYC+3 cycles later; all outputs registered, no backpressure.
// Optional RUN_LIGHT_BOUNCE_EN: automatic direction reversal every 8 steps.
module run_light_ctrl #(
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int BASE_DIV     = 25000000,
   parameter int NUM_SPEEDS   = 4
) (
   input logic              clk,
   input logic              rst,
   run_light_ctrl_if.master bus
);
   localparam int SPW = $clog2(NUM_SPEEDS);
   localparam int DBW = $clog2(DEBOUNCE_CYC);
   localparam int CW  = $clog2(BASE_DIV);

   typedef enum logic [0:0] {
      STOP = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit 0 = mode button, bit 1 = dir button.
   logic [1:0]     raw;
   logic [1:0]     sync1;
   logic [1:0]     sync2;
   logic [1:0]     deb;
   logic [1:0]     deb_q;
   logic [DBW-1:0] db_cnt [2];
   logic           mode_press;
   logic           dir_press;

   assign raw = {bus.btn_dir, bus.btn_mode};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign mode_press = deb[0] & ~deb_q[0];
   assign dir_press  = deb[1] & ~deb_q[1];

   state_t         state_q, state_d;
   logic [SPW-1:0] speed_q, speed_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  period_m1;
   logic           pulse_q, pulse_d;
   logic           dir_q, dir_d;
   logic           pend_q, pend_d;
   logic           running_q;
   logic           flip;
   logic           auto_flip;
`ifdef RUN_LIGHT_BOUNCE_EN
   logic [2:0]     step_q, step_d;
`endif

   assign period_m1 = CW'((BASE_DIV >> speed_q) - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= STOP;
         speed_q   <= '0;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         dir_q     <= 1'b1;
         pend_q    <= 1'b0;
         running_q <= 1'b0;
`ifdef RUN_LIGHT_BOUNCE_EN
         step_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         speed_q   <= speed_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         dir_q     <= dir_d;
         pend_q    <= pend_d;
         running_q <= (state_d == RUN);
`ifdef RUN_LIGHT_BOUNCE_EN
         step_q    <= step_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      speed_d   = speed_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      pend_d    = pend_q;
      flip      = 1'b0;
      auto_flip = 1'b0;
`ifdef RUN_LIGHT_BOUNCE_EN
      step_d    = step_q;
`endif
      case (state_q)
         STOP: begin
            cnt_d = '0;
            flip  = dir_press;
            if (mode_press) begin
               state_d = RUN;
               speed_d = '0;
            end
         end
         RUN: begin
            if (mode_press) begin
               // Speed change beats a coinciding terminal count; dir request survives.
               cnt_d = '0;
               if (speed_q == SPW'(NUM_SPEEDS - 1)) begin
                  state_d = STOP;
                  speed_d = '0;
                  flip    = pend_q ^ dir_press;
                  pend_d  = 1'b0;
               end else begin
                  speed_d = speed_q + 1'b1;
                  pend_d  = pend_q ^ dir_press;
               end
            end else if (cnt_q == period_m1) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
               flip    = pend_q ^ dir_press;
               pend_d  = 1'b0;
`ifdef RUN_LIGHT_BOUNCE_EN
               if (step_q == 3'd7) begin
                  auto_flip = 1'b1;
                  step_d    = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
`endif
            end else begin
               cnt_d  = cnt_q + 1'b1;
               pend_d = pend_q ^ dir_press;
            end
         end
         default: begin
            state_d = STOP;
         end
      endcase
`ifdef RUN_LIGHT_BOUNCE_EN
      if (flip) begin
         step_d = '0;
      end
`endif
      dir_d = dir_q ^ flip ^ auto_flip;
   end

   assign bus.pulse   = pulse_q;
   assign bus.dir     = dir_q;
   assign bus.running = running_q;
   assign bus.speed   = speed_q;
endmodule

// File: tb/tb_run_light_ctrl.sv
// Bench for run_light_ctrl: directed steps then random button traffic, checked against an event-time model.
module tb_run_light_ctrl;
   localparam int D  = 4;
   localparam int BD = 16;
   localparam int NS = 4;
`ifdef RUN_LIGHT_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   run_light_ctrl_if #(.NUM_SPEEDS(NS)) bus ();

   run_light_ctrl #(
      .DEBOUNCE_CYC(D),
      .BASE_DIV    (BD),
      .NUM_SPEEDS  (NS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Edges at which a clean press is consumed by the controller.
   int mq[$];
   int dq[$];

   bit m_armed = 1'b0;
   bit m_run   = 1'b0;
   bit m_pend  = 1'b0;
   bit m_dir   = 1'b1;
   bit m_pulse = 1'b0;
   int m_spd   = 0;
   int m_nxt   = 0;
   int m_steps = 0;

   int last_pulse = -1;
   int last_gap   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference: pulses land at absolute edges m_nxt, m_nxt+P, ...; dir flips by press parity.
   always @(posedge clk) begin
      bit r, m, d, fl, au;
      cyc = cyc + 1;
      r = rst;
      #1;
      m = 1'b0;
      d = 1'b0;
      if (mq.size() > 0 && mq[0] == cyc) begin
         m = 1'b1;
         void'(mq.pop_front());
      end
      if (dq.size() > 0 && dq[0] == cyc) begin
         d = 1'b1;
         void'(dq.pop_front());
      end
      m_pulse = 1'b0;
      if (r) begin
         m_armed = 1'b1;
         m_run = 1'b0; m_spd = 0; m_dir = 1'b1; m_pend = 1'b0; m_steps = 0;
         mq.delete();
         dq.delete();
      end else if (!m_run) begin
         if (d) begin
            m_dir = ~m_dir;
            m_steps = 0;
         end
         if (m) begin
            m_run = 1'b1;
            m_spd = 0;
            m_nxt = cyc + BD;
         end
      end else if (m) begin
         if (m_spd < NS - 1) begin
            m_spd = m_spd + 1;
            m_nxt = cyc + (BD >> m_spd);
            m_pend = m_pend ^ d;
         end else begin
            m_run = 1'b0;
            m_spd = 0;
            if (m_pend ^ d) begin
               m_dir = ~m_dir;
               m_steps = 0;
            end
            m_pend = 1'b0;
         end
      end else if (cyc == m_nxt) begin
         m_pulse = 1'b1;
         m_nxt = cyc + (BD >> m_spd);
         fl = m_pend ^ d;
         m_pend = 1'b0;
         m_steps = m_steps + 1;
         au = BOUNCE && (m_steps == 8);
         if (au || fl) m_steps = 0;
         if (fl ^ au) m_dir = ~m_dir;
      end else begin
         m_pend = m_pend ^ d;
      end

      if (m_armed) begin
         chk("pulse", bus.pulse, m_pulse);
         chk("dir", bus.dir, m_dir);
         chk("running", bus.running, m_run);
         chk("speed", bus.speed, m_spd);
      end
      if (bus.pulse === 1'b1) begin
         if (last_pulse >= 0) last_gap = cyc - last_pulse;
         last_pulse = cyc;
      end
   end

   // Called at a negedge; a hold of at least D cycles is a clean press.
   task automatic press(input bit pm, input bit pd, input int hold, input int gap);
      if (pm) bus.btn_mode = 1'b1;
      if (pd) bus.btn_dir = 1'b1;
      if (hold >= D) begin
         if (pm) mq.push_back(cyc + D + 3);
         if (pd) dq.push_back(cyc + D + 3);
      end
      repeat (hold) @(negedge clk);
      bus.btn_mode = 1'b0;
      bus.btn_dir  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_until(input int tgt);
      for (int k = 0; k < 2000 && cyc < tgt; k++) @(negedge clk);
      chk("align", cyc, tgt);
   endtask

   // Consume edge at a given offset from a future terminal cycle, far enough ahead to reach.
   function automatic int next_term(input int off);
      int tc;
      tc = m_nxt + off;
      while (tc - (D + 3) <= cyc) tc = tc + (BD >> m_spd);
      return tc;
   endfunction

   task automatic press_at(input bit pm, input bit pd, input int tc);
      wait_until(tc - (D + 3));
      press(pm, pd, D, D + 3);
   endtask

   task automatic goto_speed(input int s);
      for (int k = 0; k < 10 && !(m_run && m_spd == s); k++) press(1'b1, 1'b0, D, D + 3);
      chk("goto_speed", bus.speed, s);
   endtask

   initial begin
      int c0, tc, tdir, r;
      bus.btn_mode = 1'b0;
      bus.btn_dir  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_pulse", bus.pulse, 0);
      chk("rst_dir", bus.dir, 1);
      chk("rst_running", bus.running, 0);
      chk("rst_speed", bus.speed, 0);
      repeat (100) @(negedge clk);

      // Glitch shorter than the debounce window, then a real press.
      press(1'b1, 1'b0, 3, 12);
      chk("glitch_running", bus.running, 0);
      c0 = cyc;
      bus.btn_mode = 1'b1;
      mq.push_back(c0 + D + 3);
      repeat (6) @(negedge clk);
      chk("run_before_7", bus.running, 0);
      @(negedge clk);
      chk("run_at_7", bus.running, 1);
      repeat (3) @(negedge clk);
      bus.btn_mode = 1'b0;
      repeat (D + 3) @(negedge clk);

      // Step periods per speed, then wrap back to STOP.
      repeat (40) @(negedge clk);
      chk("gap_s0", last_gap, 16);
      for (int s = 1; s < NS; s++) begin
         press(1'b1, 1'b0, D, D + 3);
         repeat (3 * (BD >> s) + 4) @(negedge clk);
         chk("gap_speed", last_gap, BD >> s);
      end
      press(1'b1, 1'b0, D, D + 3);
      repeat (40) @(negedge clk);
      chk("stop_running", bus.running, 0);
      chk("stop_speed", bus.speed, 0);

      // Deferred direction change, then two presses cancelling inside one period.
      press(1'b1, 1'b0, D, D + 3);
      repeat (20) @(negedge clk);
      press_at(1'b0, 1'b1, next_term(-8));
      repeat (40) @(negedge clk);
      chk("dir_toggled", bus.dir, 0);
      press_at(1'b0, 1'b1, next_term(1));
      press(1'b0, 1'b1, D, D + 3);
      repeat (40) @(negedge clk);
      chk("dir_cancelled", bus.dir, 0);

      // Mode press on the terminal cycle, with a dir request pending.
      tdir = next_term(-12);
      press_at(1'b0, 1'b1, tdir);
      press_at(1'b1, 1'b0, tdir + 12);
      repeat (30) @(negedge clk);
      press(1'b1, 1'b1, D, D + 3);
      repeat (30) @(negedge clk);

      // Long run at the fastest speed.
      goto_speed(NS - 1);
      repeat (60) @(negedge clk);

      // Reset at speed 2 with a dir request pending.
      goto_speed(2);
      repeat (10) @(negedge clk);
      tc = next_term(-3);
      wait_until(tc - (D + 3));
      bus.btn_dir = 1'b1;
      dq.push_back(tc);
      repeat (D) @(negedge clk);
      bus.btn_dir = 1'b0;
      wait_until(tc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_pulse", bus.pulse, 0);
      chk("rst2_dir", bus.dir, 1);
      chk("rst2_running", bus.running, 0);
      repeat (100) @(negedge clk);

      // Random button traffic.
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 11);
         if (r < 4) press(1'b1, 1'b0, D + $urandom_range(0, 3), D + 3 + $urandom_range(0, 25));
         else if (r < 8) press(1'b0, 1'b1, D + $urandom_range(0, 3), D + 3 + $urandom_range(0, 25));
         else if (r == 8) press(1'b1, 1'b1, D, D + 3 + $urandom_range(0, 10));
         else if (r == 9) press($urandom_range(0, 1) == 1, 1'b1, $urandom_range(1, D - 1), D + 3);
         else if (r == 10) repeat ($urandom_range(1, 40)) @(negedge clk);
         else begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end
      end
      repeat (30) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
